// File: rtl/pudding_pkg.sv
// Shared types for the PUDDING DAC serial loader: opcodes, FSM states and
// the default daisychain length.
package pudding_pkg;

  localparam int NBITS_DEFAULT = 128;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ       = 2'b01,
    OP_WRITE_READ = 2'b10,
    OP_SET_EN     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BND,
    LOAD,
    SHIFT,
    COMMIT,
    EN
  } state_e;

  // Opcodes that capture the target state register through tgt_sdo.
  function automatic logic op_reads(input op_e op);
    return (op == OP_READ) || (op == OP_WRITE_READ);
  endfunction

endpackage

// File: rtl/pudding_tick_gen.sv
// Free-running phase counter that generates the target clock and a strobe
// marking the clk edge on which the target clock falls.
module pudding_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tgt_clk,
  output logic bnd
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] ph_q, ph_d;
  logic          tgt_clk_q, tgt_clk_d;

  always_comb begin
    ph_d      = (ph_q == PW'(DIV-1)) ? '0 : ph_q + 1'b1;
    tgt_clk_d = (ph_d >= PW'(DIV/2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_q      <= '0;
      tgt_clk_q <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      tgt_clk_q <= tgt_clk_d;
    end
  end

  // High in the last phase: the coming edge enters ph==0, where tgt_clk falls
  // and the pins may change, a full half-period away from the sampling edge.
  assign bnd     = (ph_q == PW'(DIV-1));
  assign tgt_clk = tgt_clk_q;

endmodule

// File: rtl/pudding_dac_loader.sv
// Host-side master for the PUDDING DAC serial load interface: turns a command
// into datum/shift/transfer/dir/en pin ticks and captures readback from tgt_sdo.
module pudding_dac_loader
  import pudding_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [NBITS-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NBITS-1:0] rsp_data,
  output logic             busy,
  output logic             tgt_clk,
  output logic             tgt_datum,
  output logic             tgt_shift,
  output logic             tgt_transfer,
  output logic             tgt_dir,
  output logic             tgt_en,
  input  logic             tgt_sdo
);

  localparam int CW = $clog2(NBITS);

  logic bnd;

  pudding_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt_clk (tgt_clk),
    .bnd     (bnd)
  );

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic [NBITS-1:0] cap_q, cap_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             datum_q, datum_d;
  logic             shift_q, shift_d;
  logic             xfer_q, xfer_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             done;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sreg_d      = sreg_q;
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    datum_d     = datum_q;
    shift_d     = shift_q;
    xfer_d      = xfer_q;
    dir_d       = dir_q;
    en_d        = en_q;
    rsp_valid_d = rsp_valid_q;
    done        = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    // Each state names the tick currently on the pins; a boundary ends it.
    case (state_q)
      IDLE: begin
        if (cmd_valid && !rsp_valid_q) begin
          op_d    = op_e'(cmd_op);
          sreg_d  = cmd_data;
          cap_d   = '0;
          state_d = WAIT_BND;
        end
      end
      WAIT_BND: begin
        if (bnd) begin
          case (op_q)
            OP_WRITE: begin
              state_d = SHIFT;
              shift_d = 1'b1;
              datum_d = sreg_q[NBITS-1];
              sreg_d  = {sreg_q[NBITS-2:0], 1'b0};
              cnt_d   = '0;
            end
            OP_SET_EN: begin
              state_d = EN;
              en_d    = sreg_q[0];
            end
            default: begin
              state_d = LOAD;
              xfer_d  = 1'b1;
              dir_d   = 1'b0;
              // A plain READ shifts zeros into the chain.
              if (op_q == OP_READ) sreg_d = '0;
            end
          endcase
        end
      end
      LOAD: begin
        if (bnd) begin
          cap_d   = {cap_q[NBITS-2:0], tgt_sdo};
          state_d = SHIFT;
          xfer_d  = 1'b0;
          dir_d   = 1'b0;
          shift_d = 1'b1;
          datum_d = sreg_q[NBITS-1];
          sreg_d  = {sreg_q[NBITS-2:0], 1'b0};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bnd) begin
          if (cnt_q == CW'(NBITS-1)) begin
            cnt_d = '0;
            if (op_q == OP_READ) begin
              done = 1'b1;
            end else begin
              state_d = COMMIT;
              shift_d = 1'b0;
              datum_d = 1'b0;
              xfer_d  = 1'b1;
              dir_d   = 1'b1;
            end
          end else begin
            if (op_reads(op_q)) cap_d = {cap_q[NBITS-2:0], tgt_sdo};
            cnt_d   = cnt_q + 1'b1;
            datum_d = sreg_q[NBITS-1];
            sreg_d  = {sreg_q[NBITS-2:0], 1'b0};
          end
        end
      end
      COMMIT, EN: begin
        if (bnd) done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d     = IDLE;
      datum_d     = 1'b0;
      shift_d     = 1'b0;
      xfer_d      = 1'b0;
      dir_d       = 1'b0;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_WRITE;
      sreg_q      <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      datum_q     <= 1'b0;
      shift_q     <= 1'b0;
      xfer_q      <= 1'b0;
      dir_q       <= 1'b0;
      en_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sreg_q      <= sreg_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      datum_q     <= datum_d;
      shift_q     <= shift_d;
      xfer_q      <= xfer_d;
      dir_q       <= dir_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE) && !rsp_valid_q;
  assign busy         = (state_q != IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = cap_q;
  assign tgt_datum    = datum_q;
  assign tgt_shift    = shift_q;
  assign tgt_transfer = xfer_q;
  assign tgt_dir      = dir_q;
  assign tgt_en       = en_q;

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Directed bench for pudding_dac_loader: two loaders (DIV=4 and DIV=2), each
// driving a behavioural model of the target daisychain and state register.
module tb_pudding_dac_loader;
  import pudding_pkg::*;

  localparam int N = 128;
  localparam logic [N-1:0] A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [N-1:0] B = ~A;
  localparam logic [N-1:0] C = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [N-1:0] D = 128'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9669_6996;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid [2];
  logic         rsp_ready [2];
  logic [1:0]   cmd_op    [2];
  logic [N-1:0] cmd_data  [2];
  logic         cmd_ready [2], rsp_valid [2], busy [2], tclk [2];
  logic         datum [2], shift [2], transfer [2], dir [2], en [2], sdo [2];
  logic [N-1:0] rsp_data [2], st_w [2], chain_w [2];
  int           ticks_w [2];
  logic         bad_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DV = (g == 0) ? 4 : 2;
    logic [N-1:0] chain = '0;
    logic [N-1:0] st = '0;
    int           ticks = 0;
    logic         bad = 1'b0;

    pudding_dac_loader #(.NBITS(N), .DIV(DV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid[g]),
      .cmd_ready    (cmd_ready[g]),
      .cmd_op       (cmd_op[g]),
      .cmd_data     (cmd_data[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_data     (rsp_data[g]),
      .busy         (busy[g]),
      .tgt_clk      (tclk[g]),
      .tgt_datum    (datum[g]),
      .tgt_shift    (shift[g]),
      .tgt_transfer (transfer[g]),
      .tgt_dir      (dir[g]),
      .tgt_en       (en[g]),
      .tgt_sdo      (sdo[g])
    );

    // Target: daisychain shifts in at LSB, transfer/dir=0 loads it from the
    // state register, transfer/dir=1 commits it into the state register.
    always @(posedge tclk[g]) begin
      if (shift[g]) chain <= {chain[N-2:0], datum[g]};
      else if (transfer[g] && !dir[g]) chain <= st;
      if (transfer[g] && dir[g]) st <= chain;
      if (shift[g] || transfer[g]) ticks <= ticks + 1;
    end

    always @(negedge clk)
      if ((shift[g] && transfer[g]) || (dir[g] && !transfer[g])) bad <= 1'b1;

    assign sdo[g]     = chain[N-1];
    assign st_w[g]    = st;
    assign chain_w[g] = chain;
    assign ticks_w[g] = ticks;
    assign bad_w[g]   = bad;
  end

  int   n_vec = 0;
  int   n_bad = 0;
  int   lat, tk;
  logic tmo;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pins(input int g);
    return {cmd_ready[g], rsp_valid[g], busy[g], tclk[g], datum[g],
            shift[g], transfer[g], dir[g], en[g]};
  endfunction

  task automatic issue(input int g, input logic [1:0] op, input logic [N-1:0] d, output int t0);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready[g] && n < 100) begin @(negedge clk); n++; end
    cmd_valid[g] = 1'b1;
    cmd_op[g]    = op;
    cmd_data[g]  = d;
    t0 = ticks_w[g];
    @(posedge clk);
    @(negedge clk);
    cmd_valid[g] = 1'b0;
  endtask

  // Issues one command and waits for its response; lat counts clk edges from
  // the accepting edge to the one that raises rsp_valid.
  task automatic run(input int g, input logic [1:0] op, input logic [N-1:0] d);
    int n, t0;
    issue(g, op, d, t0);
    n = 0;
    while (!rsp_valid[g] && n < 2000) begin @(negedge clk); n++; end
    lat = n;
    tk  = ticks_w[g] - t0;
    tmo = !rsp_valid[g];
  endtask

  task automatic ack(input int g);
    rsp_ready[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[g] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic stable;
    int   n, t0;
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0;
      rsp_ready[g] = 1'b0;
      cmd_op[g]    = 2'b00;
      cmd_data[g]  = '0;
    end
    repeat (4) @(negedge clk);
    chk("rst_pins0", pins(0), 9'b1_0000_0000);
    chk("rst_pins1", pins(1), 9'b1_0000_0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rsp0", rsp_data[0], '0);

    // Test 1: WRITE A
    run(0, OP_WRITE, A);
    chk("w_tmo", tmo, 1'b0);
    chk("w_state", st_w[0], A);
    chk("w_rsp", rsp_data[0], '0);
    chk("w_lat", lat <= 130 * 4, 1'b1);
    chk("w_ticks", tk, 129);
    ack(0);

    // Test 2: READ back A
    run(0, OP_READ, C);
    chk("r_tmo", tmo, 1'b0);
    chk("r_rsp", rsp_data[0], A);
    chk("r_state", st_w[0], A);
    chk("r_ticks", tk, 129);
    ack(0);

    // Test 3: WRITE_READ B
    run(0, OP_WRITE_READ, B);
    chk("wr_rsp", rsp_data[0], A);
    chk("wr_state", st_w[0], B);
    chk("wr_ticks", tk, 130);
    ack(0);

    // Test 4: SET_EN
    run(0, OP_SET_EN, {{(N-1){1'b0}}, 1'b1});
    chk("en1", en[0], 1'b1);
    chk("en1_chain", chain_w[0], B);
    chk("en1_state", st_w[0], B);
    chk("en1_ticks", tk, 0);
    chk("en1_rsp", rsp_data[0], '0);
    ack(0);
    run(0, OP_READ, '0);
    chk("en_hold", en[0], 1'b1);
    chk("en_hold_rsp", rsp_data[0], B);
    ack(0);
    run(0, OP_SET_EN, {{(N-1){1'b1}}, 1'b0});
    chk("en0", en[0], 1'b0);
    chk("en0_state", st_w[0], B);
    ack(0);

    // Test 5: response backpressure
    run(0, OP_READ, '0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid[0] || rsp_data[0] !== B || cmd_ready[0]) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_rsp", rsp_data[0], B);
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("bp_rel_valid", rsp_valid[0], 1'b0);
    chk("bp_rel_ready", cmd_ready[0], 1'b1);

    // Test 6: reset in the middle of a WRITE
    issue(0, OP_WRITE, C, t0);
    n = 0;
    while ((ticks_w[0] - t0) < 61 && n < 2000) begin @(negedge clk); n++; end
    chk("mid_reached", (ticks_w[0] - t0) == 61 && shift[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_pins", pins(0), 9'b1_0000_0000);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid[0] || busy[0]) stable = 1'b0;
    end
    chk("mid_no_rsp", stable, 1'b1);
    chk("mid_state", st_w[0], B);
    run(0, OP_WRITE, D);
    chk("post_tmo", tmo, 1'b0);
    chk("post_state", st_w[0], D);
    chk("post_rsp", rsp_data[0], '0);
    ack(0);

    // Tests 1 and 3 again with DIV=2
    run(1, OP_WRITE, A);
    chk("d2_w_tmo", tmo, 1'b0);
    chk("d2_w_state", st_w[1], A);
    chk("d2_w_rsp", rsp_data[1], '0);
    chk("d2_w_lat", lat <= 130 * 2, 1'b1);
    chk("d2_w_ticks", tk, 129);
    ack(1);
    run(1, OP_WRITE_READ, B);
    chk("d2_wr_rsp", rsp_data[1], A);
    chk("d2_wr_state", st_w[1], B);
    chk("d2_wr_ticks", tk, 130);
    ack(1);

    chk("pins_legal0", bad_w[0], 1'b0);
    chk("pins_legal1", bad_w[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pudding_dac_loader.md
Name: pudding_dac_loader

Overview:
Host-side master for the PUDDING DAC serial load interface. It converts a 128-bit code plus an opcode into the target's pin protocol: datum, shift, transfer, dir and enable, driven against a generated target clock. It can also read back the target's state register through the daisychain MSB output (uo_out[7]). It sits in the FPGA/test-harness wrapper that drives the ASIC's ui_in and clk pins.

Parameters:
NBITS, 128, length of the target daisychain and state register.
DIV, 4, clk cycles per target clock period; must be even and >=2.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  loader idle with no pending response; accepts command
cmd_op  input  2  00 WRITE, 01 READ, 10 WRITE_READ, 11 SET_EN
cmd_data  input  NBITS  code to load; bit 0 carries the enable value for SET_EN
rsp_valid  output  1  command complete; held until rsp_ready
rsp_ready  input  1  response accepted
rsp_data  output  NBITS  captured target state (READ/WRITE_READ), else 0
busy  output  1  command in progress
tgt_clk  output  1  target clock
tgt_datum  output  1  to ui_in[0]
tgt_shift  output  1  to ui_in[1]
tgt_transfer  output  1  to ui_in[2]
tgt_dir  output  1  to ui_in[3]
tgt_en  output  1  to ui_in[4], current enable
tgt_sdo  input  1  from uo_out[7] (daisychain MSB)

Behaviour:
- Reset: all outputs 0; tgt_en 0; phase counter ph 0; FSM IDLE. Reset applied mid-command aborts it immediately: pins go to 0, no response is produced, and the target contents are undefined.
- Phase counter: ph counts 0..DIV-1 and runs freely. tgt_clk is registered and equals (ph >= DIV/2), so the target samples on the ph DIV/2-1 -> DIV/2 transition.
- Boundary: a clk cycle with ph==0, which is the target falling edge. All tgt_* pin updates happen only at boundaries. tgt_sdo is sampled only at boundaries, using the value present before the update. A "tick" is one target period between boundaries.
- Handshake: cmd_ready = IDLE && !rsp_valid. The command is latched on cmd_valid && cmd_ready. The first tick's pins are driven at the next boundary.
- Data is sent MSB first: shift tick k (k=0..NBITS-1) drives datum = cmd_data[NBITS-1-k].
- WRITE: NBITS shift ticks (shift=1), then 1 commit tick (transfer=1, dir=1). Total NBITS+1 ticks.
- READ: 1 load tick (transfer=1, dir=0), then NBITS shift ticks with datum=0. Total NBITS+1 ticks. The target state is unchanged.
- WRITE_READ: load tick, then NBITS shift ticks of cmd_data, then commit tick. Total NBITS+2 ticks.
- Capture (READ/WRITE_READ): samples are taken at the boundaries ending the load tick and the first NBITS-1 shift ticks. Capture bits shift in at the LSB, so rsp_data[NBITS-1] is the first sample. rsp_data equals the target state before the command.
- SET_EN: 1 tick. tgt_en <= cmd_data[0] at the first boundary; shift/transfer stay 0. tgt_en holds across all other ops.
- Completion: at the boundary ending the last tick, datum/shift/transfer/dir return to 0, rsp_valid <= 1, and the FSM enters IDLE. rsp_valid clears on rsp_ready; a new command can be accepted on the cycle after that.
- Never assert shift and transfer together. dir is 0 whenever transfer is 0.
- FSM states: IDLE, WAIT_BND, LOAD, SHIFT (bit counter 0..NBITS-1, wraps only on exit), COMMIT, EN.

Decomposition:
- Package pudding_pkg: op_e enum (OP_WRITE, OP_READ, OP_WRITE_READ, OP_SET_EN), NBITS_DEFAULT=128, state enum.
- Sub-module pudding_tick_gen: phase counter plus tgt_clk register and boundary pulse, parameterised by DIV.

Test Plan:
- Test 1: bench carries a behavioural model of the target (daisychain/state registers on tgt_clk). DIV=4, WRITE 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> model state matches, and rsp_valid rises within (129+1)*4 clk of acceptance with rsp_data=0.
- Test 2: WRITE A as in Test 1, then READ -> rsp_data=A and model state still A. Also check shift and transfer are never both high.
- Test 3: state=A, WRITE_READ B=~A -> rsp_data=A, model state=B, and the op takes 130 ticks.
- Test 4: SET_EN data=1 -> tgt_en=1 after the next boundary, daisychain untouched. SET_EN 0 -> tgt_en=0.
- Test 5: backpressure. Hold rsp_ready=0 for 20 cycles after completion -> rsp_valid and rsp_data stable and cmd_ready=0. Then release -> cmd_ready=1 the next cycle.
- Test 6: rst_n low at shift tick 60 of a WRITE -> next cycle all pins 0, busy=0, no rsp_valid. A subsequent WRITE completes correctly. Repeat Tests 1 and 3 with DIV=2.
